controlador_teclado: RTL and testbench

Keypad-entry controller for the microwave encoder path. Samples the ten digit keys and picks one key when several are pressed together. It drives a saturating debounce counter to confirm the press. It then issues one BCD code with a single-cycle valid strobe and holds off further codes until the keypad has been stably released. It sits between the raw keypad inputs and the level-2 encoder/time-entry logic.

---
 rtl/controlador_teclado_pkg.sv | 14 +
 rtl/controlador_teclado_contador.sv | 34 +++
 rtl/controlador_teclado.sv | 134 +++++++++++++
 tb/tb_controlador_teclado.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_teclado_pkg.sv
// Shared definitions for the keypad-entry controller: FSM state encodings
// and the default debounce length.
package controlador_teclado_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    localparam int N_DEBOUNCE_PADRAO = 7;

endpackage

// File: rtl/controlador_teclado_contador.sv
// Saturating up-counter with synchronous clear/load-one and a flag that
// marks when the programmed limit has been reached.
module contador_saturado #(
    parameter int                  LARGURA = 4,
    parameter logic [LARGURA-1:0]  LIMITE  = {LARGURA{1'b1}}
) (
    input  logic Clock,
    input  logic Clear,
    input  logic limpa,
    input  logic inicia,
    input  logic incrementa,
    output logic cheio
);

    logic [LARGURA-1:0] valor_r;

    // Count register: clear beats load-one, load-one beats increment; holds at all-ones.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            valor_r <= {LARGURA{1'b0}};
        end else if (limpa) begin
            valor_r <= {LARGURA{1'b0}};
        end else if (inicia) begin
            valor_r <= {{(LARGURA-1){1'b0}}, 1'b1};
        end else if (incrementa && (valor_r != {LARGURA{1'b1}})) begin
            valor_r <= valor_r + {{(LARGURA-1){1'b0}}, 1'b1};
        end else begin
            valor_r <= valor_r;
        end
    end

    assign cheio = (valor_r == LIMITE);

endmodule

// File: rtl/controlador_teclado.sv
// Keypad-entry controller: picks the lowest pressed digit, debounces press
// and release, and emits one BCD code with a single-cycle strobe per press.
module controlador_teclado
    import controlador_teclado_pkg::*;
#(
    parameter int N_DEBOUNCE = N_DEBOUNCE_PADRAO
) (
    input  logic       Clock,
    input  logic       Clear,
    input  logic       habilita,
    input  logic [9:0] teclas,
    output logic [3:0] codigo,
    output logic       valido,
    output logic       ocupado
);

    // The same limit serves both phases: the last press sample and the last
    // release sample are both taken while the count reads N_DEBOUNCE-1.
    localparam logic [3:0] LIMITE_C = 4'(N_DEBOUNCE - 1);

    function automatic logic [3:0] prioridade(input logic [9:0] t);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (t[i]) begin
                r = 4'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    estado_t    estado_r, estado_s;
    logic [3:0] tecla_r, tecla_s;
    logic [3:0] codigo_r, codigo_s;
    logic       valido_r, valido_s;
    logic       ocupado_r;
    logic [3:0] tecla_atual_s;
    logic       ha_tecla_s;
    logic       limpa_s, inicia_s, incrementa_s, cheio_s;

    assign tecla_atual_s = prioridade(teclas);
    assign ha_tecla_s    = |teclas;

    contador_saturado #(
        .LARGURA (4),
        .LIMITE  (LIMITE_C)
    ) u_contador (
        .Clock      (Clock),
        .Clear      (Clear),
        .limpa      (limpa_s),
        .inicia     (inicia_s),
        .incrementa (incrementa_s),
        .cheio      (cheio_s)
    );

    // Next-state, counter control and next output values.
    always_comb begin
        estado_s     = estado_r;
        tecla_s      = tecla_r;
        codigo_s     = codigo_r;
        valido_s     = 1'b0;
        limpa_s      = 1'b0;
        inicia_s     = 1'b0;
        incrementa_s = 1'b0;
        case (estado_r)
            IDLE: begin
                if (habilita && ha_tecla_s) begin
                    tecla_s  = tecla_atual_s;
                    inicia_s = 1'b1;
                    estado_s = DEBOUNCE;
                end else begin
                    limpa_s = 1'b1;
                end
            end
            DEBOUNCE: begin
                if (!ha_tecla_s) begin
                    limpa_s  = 1'b1;
                    estado_s = IDLE;
                end else if (tecla_atual_s != tecla_r) begin
                    tecla_s  = tecla_atual_s;
                    inicia_s = 1'b1;
                end else if (cheio_s) begin
                    codigo_s = tecla_r;
                    valido_s = 1'b1;
                    estado_s = EMIT;
                end else begin
                    incrementa_s = 1'b1;
                end
            end
            EMIT: begin
                limpa_s  = 1'b1;
                estado_s = RELEASE;
            end
            RELEASE: begin
                if (ha_tecla_s) begin
                    limpa_s = 1'b1;
                end else if (cheio_s) begin
                    limpa_s  = 1'b1;
                    estado_s = IDLE;
                end else begin
                    incrementa_s = 1'b1;
                end
            end
            default: begin
                limpa_s  = 1'b1;
                estado_s = IDLE;
            end
        endcase
    end

    // State, latched key and registered outputs.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            estado_r  <= IDLE;
            tecla_r   <= 4'd0;
            codigo_r  <= 4'd0;
            valido_r  <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            estado_r  <= estado_s;
            tecla_r   <= tecla_s;
            codigo_r  <= codigo_s;
            valido_r  <= valido_s;
            ocupado_r <= (estado_s != IDLE);
        end
    end

    assign codigo  = codigo_r;
    assign valido  = valido_r;
    assign ocupado = ocupado_r;

endmodule

// File: tb/tb_controlador_teclado.sv
// Self-checking bench for controlador_teclado: directed table, corner-case
// sequences and random keypad traffic against a sample-history model.
module tb_controlador_teclado;

    localparam int N = 7;

    logic       Clock_tb;
    logic       Clear;
    logic       habilita;
    logic [9:0] teclas;
    logic [3:0] codigo;
    logic       valido;
    logic       ocupado;

    int checks   = 0;
    int failures = 0;

    controlador_teclado #(.N_DEBOUNCE(N)) dut (
        .Clock    (Clock_tb),
        .Clear    (Clear),
        .habilita (habilita),
        .teclas   (teclas),
        .codigo   (codigo),
        .valido   (valido),
        .ocupado  (ocupado)
    );

    initial Clock_tb = 1'b0;
    always #5 Clock_tb = ~Clock_tb;

    // Reference model: tracks runs of samples rather than a counter register.
    bit pressing, emitting, releasing;
    int streak, zeros, m_key, m_code;
    bit m_valido;

    function automatic int lowest_key(input logic [9:0] t);
        for (int b = 0; b < 10; b++) if (t[b]) return b;
        return -1;
    endfunction

    task automatic model_reset();
        pressing = 0; emitting = 0; releasing = 0;
        streak = 0; zeros = 0; m_key = 0; m_code = 0; m_valido = 0;
    endtask

    task automatic model_edge(input logic h, input logic [9:0] t);
        int k;
        k = lowest_key(t);
        m_valido = 0;
        if (emitting) begin
            emitting = 0; releasing = 1; zeros = 0;
        end else if (releasing) begin
            zeros = (t == 10'd0) ? zeros + 1 : 0;
            if (zeros == N) releasing = 0;
        end else if (pressing) begin
            if (k < 0) pressing = 0;
            else if (k == m_key) begin
                streak++;
                if (streak == N) begin
                    m_valido = 1; m_code = k; pressing = 0; emitting = 1;
                end
            end else begin
                m_key = k; streak = 1;
            end
        end else if (h && k >= 0) begin
            pressing = 1; m_key = k; streak = 1;
        end
    endtask

    task automatic check(input string nome, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, got, exp, $time);
        end
    endtask

    task automatic step(input logic h, input logic [9:0] t);
        habilita = h;
        teclas   = t;
        @(posedge Clock_tb);
        #1;
        model_edge(h, t);
        check("model_valido", 16'(valido), 16'(m_valido));
        check("model_codigo", 16'(codigo), 16'(m_code));
        check("model_ocupado", 16'(ocupado), 16'(pressing || emitting || releasing));
    endtask

    task automatic check_reset_outputs(input string nome);
        check({nome, "_codigo"}, 16'(codigo), 16'd0);
        check({nome, "_valido"}, 16'(valido), 16'd0);
        check({nome, "_ocupado"}, 16'(ocupado), 16'd0);
    endtask

    typedef struct {
        logic       h;
        logic [9:0] t;
        logic       v;
        logic [3:0] c;
        logic       o;
    } vetor_t;

    vetor_t tabela [18];
    int     pulsos;
    int     run;
    logic [9:0] val;
    logic       hv;

    initial begin
        // Clean press of digit 3 for 10 samples, then release.
        for (int i = 0; i < 18; i++) begin
            tabela[i].h = 1'b1;
            tabela[i].t = (i < 10) ? 10'h008 : 10'h000;
            tabela[i].v = (i == 6);
            tabela[i].c = (i >= 6) ? 4'd3 : 4'd0;
            tabela[i].o = (i < 16);
        end

        Clear = 1'b0; habilita = 1'b0; teclas = 10'd0;
        model_reset();
        repeat (3) @(posedge Clock_tb);
        #1;
        check_reset_outputs("initial_reset");
        Clear = 1'b1;

        pulsos = 0;
        for (int i = 0; i < 18; i++) begin
            step(tabela[i].h, tabela[i].t);
            check("table_valido", 16'(valido), 16'(tabela[i].v));
            check("table_codigo", 16'(codigo), 16'(tabela[i].c));
            check("table_ocupado", 16'(ocupado), 16'(tabela[i].o));
            pulsos += int'(valido);
        end
        check("clean_press_pulses", 16'(pulsos), 16'd1);

        // Reset held with key 5 pressed, then released with the key still held.
        Clear = 1'b0; teclas = 10'h020; habilita = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge Clock_tb); #1;
            check_reset_outputs("reset_held");
        end
        Clear = 1'b1;
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 10'h020);
            check("reset_release_strobe", 16'(valido), 16'(i == N));
        end
        check("reset_release_codigo", 16'(codigo), 16'd5);
        repeat (N + 2) step(1'b1, 10'h000);

        // Bounce: short burst must not emit; the following full burst does.
        repeat (4) begin
            step(1'b1, 10'h100);
            check("bounce_first_burst", 16'(valido), 16'd0);
        end
        step(1'b1, 10'h000);
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 10'h100);
            check("bounce_strobe", 16'(valido), 16'(i == N));
        end
        check("bounce_codigo", 16'(codigo), 16'd8);
        repeat (N + 2) step(1'b1, 10'h000);

        // Two keys together: lowest wins.
        repeat (N) step(1'b1, 10'h084);
        check("multi_strobe", 16'(valido), 16'd1);
        check("multi_codigo", 16'(codigo), 16'd2);
        repeat (N + 2) step(1'b1, 10'h000);
        // Dropping the lower key mid-press restarts the debounce on key 7.
        repeat (3) step(1'b1, 10'h084);
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 10'h080);
            check("multi_restart_strobe", 16'(valido), 16'(i == N));
        end
        check("multi_restart_codigo", 16'(codigo), 16'd7);
        repeat (N + 2) step(1'b1, 10'h000);

        // Long hold, then a release blip restarts the release count.
        pulsos = 0;
        repeat (40) begin
            step(1'b1, 10'h002);
            pulsos += int'(valido);
        end
        repeat (5) step(1'b1, 10'h000);
        step(1'b1, 10'h010);
        for (int i = 1; i <= N; i++) begin
            step(1'b1, 10'h000);
            pulsos += int'(valido);
            check("release_blip_ocupado", 16'(ocupado), 16'(i < N));
        end
        check("held_key_pulses", 16'(pulsos), 16'd1);
        check("held_key_codigo", 16'(codigo), 16'd1);

        // Disabled: a held key is ignored.
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 10'h010);
            check("disabled_ocupado", 16'(ocupado), 16'd0);
            check("disabled_valido", 16'(valido), 16'd0);
        end
        step(1'b1, 10'h000);

        // Async clear mid-debounce takes effect before the next edge.
        repeat (4) step(1'b1, 10'h010);
        check("pre_clear_ocupado", 16'(ocupado), 16'd1);
        #3;
        Clear = 1'b0;
        #1;
        check_reset_outputs("async_clear");
        model_reset();
        repeat (2) begin
            @(posedge Clock_tb); #1;
            check_reset_outputs("async_clear_held");
        end
        teclas = 10'h000;
        Clear = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'h000);
            check("post_clear_no_strobe", 16'(valido), 16'd0);
        end

        // Random keypad traffic with runs of held values.
        for (int i = 0; i < 600; i++) begin
            run = $urandom_range(1, 12);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: val = 10'd0;
                4, 5, 6, 7: val = 10'd1 << $urandom_range(0, 9);
                default:    val = 10'($urandom_range(1, 1023));
            endcase
            hv = ($urandom_range(0, 9) != 0);
            repeat (run) step(hv, val);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
